// File: rtl/irrigation_sequencer.sv
// ---------------------------------------------------------------------------
// irrigation_sequencer
//
// Sequences the single shared water line between the sprinkler and drip
// channels. A started channel stays open for at least MIN_ON_CYCLES. Every
// channel stop, and every cleared fault, is followed by DEADTIME_CYCLES with
// both valves closed. A fault forces an immediate, latched shutdown that
// waits for an operator acknowledge. All outputs come from flops, so a
// glitch on the combinational trigger inputs cannot chatter a valve.
//
// Optional feature (macro IRRIGATION_SEQ_WATCHDOG_EN):
//   Adds a per-activation run-time limit of MAX_RUN_CYCLES. When it expires
//   the channel is closed and the sticky timeout_o flag is set. While the
//   flag is set no new channel starts. The flag is cleared by fault_clear_i
//   while fault_i is low. Without the macro there is no watchdog logic and
//   timeout_o is tied low.
//
// Parameters:
//   MIN_ON_CYCLES    minimum valve open time per activation (>= 1)
//   DEADTIME_CYCLES  both-closed gap after a stop or a fault clear (>= 1)
//   MAX_RUN_CYCLES   watchdog limit, used only with the macro (> MIN_ON_CYCLES)
//   CNT_W            width of the shared cycle counter
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_n_i            asynchronous active-low reset
//   sprinkler_req_i    sprinkler request (wins over drip when both are high)
//   drip_req_i         drip request
//   fault_i            error or alarm, forces FAULT
//   fault_clear_i      operator acknowledge
//   sprinkler_valve_o  sprinkler valve drive
//   drip_valve_o       drip valve drive
//   busy_o             high whenever the sequencer is not IDLE
//   fault_o            high in FAULT
//   timeout_o          sticky watchdog flag
//   state_o            IDLE=0 SPRINKLE=1 DRIP=2 DEAD=3 FAULT=4
// ---------------------------------------------------------------------------
module irrigation_sequencer #(
  parameter int MIN_ON_CYCLES   = 8,
  parameter int DEADTIME_CYCLES = 4,
  parameter int MAX_RUN_CYCLES  = 64,
  parameter int CNT_W           = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sprinkler_req_i,
  input  logic       drip_req_i,
  input  logic       fault_i,
  input  logic       fault_clear_i,
  output logic       sprinkler_valve_o,
  output logic       drip_valve_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_DEAD     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  // Last counter value of the minimum run and of the dead time. The counter
  // is 0 in the first cycle of a state, so value N-1 marks the Nth cycle.
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Reject parameter sets that the shared counter cannot represent.
  if ((MIN_ON_CYCLES < 1) || (DEADTIME_CYCLES < 1) ||
      (MAX_RUN_CYCLES <= MIN_ON_CYCLES) ||
      (MAX_RUN_CYCLES > (2 ** CNT_W) - 1) ||
      (DEADTIME_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_params
    $error("irrigation_sequencer: illegal parameter set");
  end

  // Saturating increment so a long run cannot wrap the counter back below
  // the minimum-run threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + CNT_W'(1'b1);
    end
    return result;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             watchdog_hit_s;
  logic             start_block_s;
  logic             sprinkler_valve_r;
  logic             drip_valve_r;
  logic             busy_r;
  logic             fault_r;

`ifdef IRRIGATION_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

  logic timeout_r;
  logic timeout_s;

  // Watchdog fires on the last allowed cycle of an activation whose request
  // is still held. A released request is handled by the normal exit path.
  always_comb begin
    watchdog_hit_s = 1'b0;
    if (((state_r == ST_SPRINKLE) && sprinkler_req_i) ||
        ((state_r == ST_DRIP) && drip_req_i)) begin
      watchdog_hit_s = (cnt_r >= WD_LAST);
    end else begin
      watchdog_hit_s = 1'b0;
    end
  end

  // Sticky timeout flag: acknowledge clears it, a watchdog hit sets it
  // unless a fault takes the same edge.
  always_comb begin
    timeout_s = timeout_r;
    if (!fault_i && fault_clear_i) begin
      timeout_s = 1'b0;
    end else if (watchdog_hit_s && !fault_i) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = timeout_r;
    end
  end

  // Timeout flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_s;
    end
  end

  assign start_block_s = timeout_r;
  assign timeout_o     = timeout_r;
`else
  assign watchdog_hit_s = 1'b0;
  assign start_block_s  = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  // Next-state and counter logic. A fault overrides every other transition,
  // including the minimum run and the dead time.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (start_block_s) begin
          state_s = ST_IDLE;
        end else if (sprinkler_req_i) begin
          state_s = ST_SPRINKLE;
        end else if (drip_req_i) begin
          state_s = ST_DRIP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SPRINKLE: begin
        if (watchdog_hit_s) begin
          state_s = ST_DEAD;
        end else if (!sprinkler_req_i && (cnt_r >= MIN_LAST)) begin
          state_s = ST_DEAD;
        end else begin
          state_s = ST_SPRINKLE;
        end
      end
      ST_DRIP: begin
        if (watchdog_hit_s) begin
          state_s = ST_DEAD;
        end else if (!drip_req_i && (cnt_r >= MIN_LAST)) begin
          state_s = ST_DEAD;
        end else begin
          state_s = ST_DRIP;
        end
      end
      ST_DEAD: begin
        if (cnt_r >= DEAD_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DEAD;
        end
      end
      ST_FAULT: begin
        if (!fault_i && fault_clear_i) begin
          state_s = ST_DEAD;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (fault_i) begin
      state_s = ST_FAULT;
    end else begin
      state_s = state_s;
    end

    // The counter restarts on every state entry and only counts in the
    // timed states.
    if (state_s != state_r) begin
      cnt_s = '0;
    end else if ((state_r == ST_SPRINKLE) || (state_r == ST_DRIP) ||
                 (state_r == ST_DEAD)) begin
      cnt_s = sat_inc(cnt_r);
    end else begin
      cnt_s = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers are decoded from the next state, so they change on
  // the same edge as the state and the valves never see input glitches.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sprinkler_valve_r <= 1'b0;
      drip_valve_r      <= 1'b0;
      busy_r            <= 1'b0;
      fault_r           <= 1'b0;
    end else begin
      sprinkler_valve_r <= (state_s == ST_SPRINKLE);
      drip_valve_r      <= (state_s == ST_DRIP);
      busy_r            <= (state_s != ST_IDLE);
      fault_r           <= (state_s == ST_FAULT);
    end
  end

  assign sprinkler_valve_o = sprinkler_valve_r;
  assign drip_valve_o      = drip_valve_r;
  assign busy_o            = busy_r;
  assign fault_o           = fault_r;
  assign state_o           = state_r;

endmodule

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Synchronous sequencer between the combinational irrigation triggers (sprinkler/drip request, error/alarm) and the physical valve drivers. It time-shares the single water line between the sprinkler and drip channels and enforces a minimum run time and a dead time between activations. It also provides a latched fault shutdown. All outputs are registered, so sensor glitches on the combinational trigger path cannot chatter the valves.

## Interface
- MIN_ON_CYCLES, 8, minimum cycles a channel valve stays open once started (≥1)
- DEADTIME_CYCLES, 4, cycles both valves are held closed after any channel stops or a fault clears (≥1)
- MAX_RUN_CYCLES, 64, watchdog limit per activation; used only with the configuration macro (> MIN_ON_CYCLES)
- CNT_W, 8, width of the shared cycle counter; every cycle parameter must be ≤ 2^CNT_W−1
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- sprinkler_req_i  in  1  sprinkler request from the trigger logic
- drip_req_i  in  1  drip request from the trigger logic
- fault_i  in  1  error indicator OR alarm state
- fault_clear_i  in  1  operator acknowledge
- sprinkler_valve_o  out  1  sprinkler valve drive
- drip_valve_o  out  1  drip valve drive
- busy_o  out  1  high in any state other than IDLE
- fault_o  out  1  high in FAULT
- timeout_o  out  1  sticky watchdog flag (constant 0 without the macro)
- state_o  out  3  IDLE=0, SPRINKLE=1, DRIP=2, DEAD=3, FAULT=4

## Operation
- Reset: state IDLE, counter 0, every output 0.
- IDLE:
  - sprinkler_req_i=1 → SPRINKLE. Sprinkler has priority if both requests are high.
  - Otherwise drip_req_i=1 → DRIP.
  - Counter is cleared on every state entry.
- SPRINKLE/DRIP:
  - Only the matching valve is 1; the counter increments and saturates.
  - Exit to DEAD when the channel's request is 0 and the counter is ≥ MIN_ON_CYCLES−1.
  - A request that drops earlier keeps the valve open until the minimum is met.
  - The other channel's request is ignored. No direct SPRINKLE↔DRIP transition; the path always goes through DEAD.
- DEAD:
  - Both valves 0 for exactly DEADTIME_CYCLES cycles, then IDLE.
  - Requests are ignored during DEAD.
- FAULT:
  - fault_i=1 in any state → FAULT on the next edge. This overrides the minimum run time and dead time.
  - Both valves 0 while in FAULT.
  - Leave to DEAD only when fault_i=0 and fault_clear_i=1 in the same cycle.
  - fault_clear_i while fault_i=1 is ignored.
- Simultaneous events:
  - fault_i has priority over all other transitions.
  - The watchdog has priority over a normal exit in the same cycle.
- Valve invariant: sprinkler_valve_o and drip_valve_o are never both 1.

## Timing
- Request sampled at edge N → valve high after edge N (1-cycle latency).
- Valve open-time for a single request pulse of any length L: max(L, MIN_ON_CYCLES) cycles.
- Closing edge → earliest next opening: DEADTIME_CYCLES + 1 cycles (DEAD, then the IDLE sampling cycle).
- fault_i high at edge N → valves low after edge N.
- rst_n_i asserted mid-run:
  - Valves drop asynchronously and immediately.
  - After release: IDLE, with no dead time enforced.

## Configuration
- Macro: IRRIGATION_SEQ_WATCHDOG_EN.
- Defined:
  - In SPRINKLE/DRIP, when the counter reaches MAX_RUN_CYCLES−1 with the request still 1, go to DEAD and set timeout_o.
  - While timeout_o=1, IDLE starts no channel.
  - timeout_o is cleared by fault_clear_i=1 when fault_i=0.
  - fault_i still takes FAULT priority.
- Undefined:
  - No watchdog logic; timeout_o is tied 0.
  - A channel runs as long as its request stays high.

## Test plan
- Reset, then sprinkler_req_i pulse of 2 cycles → sprinkler_valve_o high exactly 8 cycles, then state_o=3 for 4 cycles, then 0.
- Both requests high from IDLE → sprinkler opens first. Drop sprinkler_req_i at cycle 20 → sprinkler closes at cycle 21, 4 dead cycles, then drip_valve_o opens. Valves never overlap.
- Drip running, fault_i=1 at cycle 3 → drip_valve_o=0 next cycle, fault_o=1.
  - fault_clear_i while fault_i=1 → no change.
  - fault_i=0 with clear → DEAD for 4 cycles, then IDLE.
- Watchdog (macro defined): drip_req_i held high → drip closes after 64 cycles, timeout_o=1, no restart. fault_clear_i → timeout_o=0 and drip restarts.
- rst_n_i low mid-SPRINKLE, then released with sprinkler_req_i=1 → all outputs 0 during reset; valve reopens 1 cycle after release.
